// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Round-robin on ties; one access in flight at a time with a wait-state timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,

  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] ls_be_i,
  output logic                    ls_gnt_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,

  output logic                    bus_err_o,

  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  owner_ls_q, owner_ls_d;
  logic                  last_ls_q, last_ls_d;
  logic [CntWidth-1:0]   wait_q, wait_d;

  logic any_req;
  logic pick_ls;
  logic accept;
  logic wait_expired;
  logic resp_active;

  assign any_req      = if_req_i | ls_req_i;
  // On a tie, load/store wins only if fetch was granted last.
  assign pick_ls      = ls_req_i & (~if_req_i | ~last_ls_q);
  assign accept       = (state_q == StIdle) & any_req & ~rst_i;
  assign wait_expired = (wait_q == CntLast);
  assign resp_active  = (state_q == StResp) & ~rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready_i || wait_expired) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    owner_ls_d  = owner_ls_q;
    last_ls_d   = last_ls_q;
    wait_d      = wait_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          mem_en_d   = 1'b1;
          owner_ls_d = pick_ls;
          last_ls_d  = pick_ls;
          wait_d     = '0;
          err_d      = 1'b0;
          if (pick_ls) begin
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
            mem_be_d    = ls_be_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end
      StBusy: begin
        if (mem_ready_i) begin
          mem_en_d = 1'b0;
          rdata_d  = mem_we_q ? '0 : mem_rdata_i;
          err_d    = 1'b0;
        end else begin
          wait_d = wait_q + CntWidth'(1);
          if (wait_expired) begin
            mem_en_d = 1'b0;
            rdata_d  = '0;
            err_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b1;
      wait_q      <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      owner_ls_q  <= owner_ls_d;
      last_ls_q   <= last_ls_d;
      wait_q      <= wait_d;
    end
  end

  // Outputs; non-owner response ports stay at zero
  always_comb begin
    if_gnt_o    = accept & ~pick_ls;
    ls_gnt_o    = accept & pick_ls;
    if_rvalid_o = resp_active & ~owner_ls_q;
    ls_rvalid_o = resp_active & owner_ls_q;
    if_rdata_o  = if_rvalid_o ? rdata_q : '0;
    ls_rdata_o  = ls_rvalid_o ? rdata_q : '0;
    bus_err_o   = resp_active & err_q;
    mem_en_o    = mem_en_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    mem_be_o    = mem_be_q;
  end

endmodule
